// File: rtl/ssd_driver.sv
// -----------------------------------------------------------------------------
// ssd_driver
//
// Time-multiplexed driver for an 8-digit, common-anode, seven-segment display
// showing a 32-bit value as eight hex digits.
//
// Each digit owns a slot of REFRESH_DIV clock cycles. The digit is driven for
// the first REFRESH_DIV-GUARD cycles of its slot. It is dark for the last
// GUARD cycles, so the previous digit's pattern does not ghost onto the next
// anode. Optional leading-zero blanking darkens the upper digits that hold
// only leading zeros. Digit 0 always shows.
//
// Parameters
//   REFRESH_DIV : clock cycles per digit slot (2 .. 2^24)
//   GUARD       : dark cycles at the end of each slot (1 .. REFRESH_DIV-1)
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous reset, active low
//   data_in  : value to display
//   load     : when high at a clock edge, data_in is captured into shown
//   blank_lz : leading-zero blanking enable, used live every cycle
//   anode    : digit enables, active low; bit i selects hex digit i
//   seg      : segments {g,f,e,d,c,b,a}, active low
//   dp       : decimal point, active low; always off
//   shown    : the value currently latched for display
// -----------------------------------------------------------------------------
module ssd_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [31:0] shown
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DRIVE_LEN = CW'(REFRESH_DIV - GUARD);

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    state_t        state_reg,  state_next;
    logic [CW-1:0] cnt_reg,    cnt_next;
    logic [2:0]    idx_reg,    idx_next;
    logic [31:0]   shown_reg,  shown_next;
    logic [7:0]    anode_reg,  anode_next;
    logic [6:0]    seg_reg,    seg_next;

    logic          cnt_wrap;
    logic [3:0]    nibble;
    logic [7:0]    lz_blank;

    // Hex digit to active-low segment pattern, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    // Digit gi is a leading zero when nibbles gi..7 are all zero.
    // Digit 0 is exempt, so a value of zero still shows a single "0".
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lz
            if (gi == 0) begin : g_digit0
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = blank_lz && (shown_reg[31:4*gi] == '0);
            end
        end
    endgenerate

    assign nibble = shown_reg[{idx_reg, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_DRIVE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shown_reg <= '0;
            anode_reg <= 8'hFF;
            seg_reg   <= 7'h7F;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shown_reg <= shown_next;
            anode_reg <= anode_next;
            seg_reg   <= seg_next;
        end
    end

    always_comb begin
        cnt_wrap   = (cnt_reg == CNT_LAST);
        cnt_next   = cnt_wrap ? '0 : cnt_reg + 1'b1;
        idx_next   = cnt_wrap ? idx_reg + 3'd1 : idx_reg;
        shown_next = load ? data_in : shown_reg;

        // The state tracks the phase of the count it is loaded with.
        // This keeps state_reg consistent with cnt_reg on every cycle.
        state_next = (cnt_next < DRIVE_LEN) ? ST_DRIVE : ST_GUARD;

        // Outputs are registered from the current count, digit and value.
        // A newly loaded value appears one edge after it is captured.
        anode_next = 8'hFF;
        seg_next   = 7'h7F;
        if (state_reg == ST_DRIVE && !lz_blank[idx_reg]) begin
            anode_next = ~(8'd1 << idx_reg);
            seg_next   = hex_to_seg(nibble);
        end
    end

    assign anode = anode_reg;
    assign seg   = seg_reg;
    assign dp    = 1'b1;
    assign shown = shown_reg;

endmodule
